// File: rtl/md_issue_ctl.sv
// Requester side of the multiply/divide unit: registers MD ops toward the unit,
// stalls the E stage while an op is in flight, returns HI/LO reads, and watchdogs long waits.
module md_issue_ctl #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        e_md_op,
  input  logic [1:0]        e_mf_sel,
  input  logic [DATA_W-1:0] e_rs,
  input  logic [DATA_W-1:0] e_rt,
  input  logic              int_req,
  input  logic              md_busy,
  input  logic [DATA_W-1:0] md_hi,
  input  logic [DATA_W-1:0] md_lo,
  output logic [3:0]        md_op,
  output logic [DATA_W-1:0] md_a1,
  output logic [DATA_W-1:0] md_a2,
  output logic              md_req,
  output logic              stall,
  output logic [DATA_W-1:0] mf_data,
  output logic              mf_valid,
  output logic              wd_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUED = 2'd1,
    WAIT   = 2'd2
  } state_e;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WD_MAX  = CNT_W'(TIMEOUT);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic [3:0]        md_op_q, md_op_d;
  logic [DATA_W-1:0] md_a1_q, md_a1_d;
  logic [DATA_W-1:0] md_a2_q, md_a2_d;
  logic [DATA_W-1:0] mf_data_q, mf_data_d;
  logic              mf_valid_q, mf_valid_d;
  logic              wd_err_q, wd_err_d;

  logic md_instr_s;
  logic mf_req_s;
  logic long_op_s;
  logic wd_fire_s;

  assign md_instr_s = (e_md_op != 4'd0);
  assign mf_req_s   = (e_mf_sel == 2'b01) || (e_mf_sel == 2'b10);
  assign long_op_s  = (md_op_q >= 4'd1) && (md_op_q <= 4'd4);
  // The watchdog fires on the WAIT cycle that would bring the count up to TIMEOUT.
  assign wd_fire_s  = (state_q == WAIT) && md_busy && (wd_cnt_q == WD_LAST);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (md_instr_s && !int_req) begin
          state_d = ISSUED;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUED: begin
        if (!int_req && long_op_s) begin
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (!md_busy || wd_fire_s) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Watchdog counter: cleared on WAIT entry, counts busy WAIT cycles, saturates at TIMEOUT
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if ((state_q == ISSUED) && (state_d == WAIT)) begin
      wd_cnt_d = '0;
    end else if ((state_q == WAIT) && md_busy && (wd_cnt_q != WD_MAX)) begin
      wd_cnt_d = wd_cnt_q + CNT_W'(1);
    end else begin
      wd_cnt_d = wd_cnt_q;
    end
  end

  // Output-side next values: one-shot op, operand capture, HI/LO read, sticky error
  always_comb begin
    md_op_d    = 4'd0;
    md_a1_d    = md_a1_q;
    md_a2_d    = md_a2_q;
    mf_data_d  = mf_data_q;
    mf_valid_d = 1'b0;
    wd_err_d   = wd_err_q || wd_fire_s;
    if (state_q == IDLE) begin
      if (md_instr_s && !int_req) begin
        md_op_d = e_md_op;
        md_a1_d = e_rs;
        md_a2_d = e_rt;
      end else if (!md_instr_s && mf_req_s) begin
        mf_valid_d = 1'b1;
        mf_data_d  = (e_mf_sel == 2'b01) ? md_hi : md_lo;
      end else begin
        md_op_d = 4'd0;
      end
    end else begin
      mf_valid_d = 1'b0;
    end
  end

  // Datapath and watchdog registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt_q   <= '0;
      md_op_q    <= 4'd0;
      md_a1_q    <= '0;
      md_a2_q    <= '0;
      mf_data_q  <= '0;
      mf_valid_q <= 1'b0;
      wd_err_q   <= 1'b0;
    end else begin
      wd_cnt_q   <= wd_cnt_d;
      md_op_q    <= md_op_d;
      md_a1_q    <= md_a1_d;
      md_a2_q    <= md_a2_d;
      mf_data_q  <= mf_data_d;
      mf_valid_q <= mf_valid_d;
      wd_err_q   <= wd_err_d;
    end
  end

  // md_req is gated by reset so every output reads 0 while reset is held.
  assign md_req   = int_req && reset;
  assign stall    = (state_q != IDLE) && (md_instr_s || mf_req_s);
  assign md_op    = md_op_q;
  assign md_a1    = md_a1_q;
  assign md_a2    = md_a2_q;
  assign mf_data  = mf_data_q;
  assign mf_valid = mf_valid_q;
  assign wd_err   = wd_err_q;

endmodule

// File: tb/tb_md_issue_ctl.sv
// Randomised bench for md_issue_ctl with a behavioural MD unit and a cycle-level reference model.
module tb_md_issue_ctl;
  localparam int DW = 32;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [3:0]    e_md_op = 4'd0;
  logic [1:0]    e_mf_sel = 2'd0;
  logic [DW-1:0] e_rs = '0, e_rt = '0;
  logic          int_req = 1'b0;
  logic          md_busy = 1'b0;
  logic [DW-1:0] md_hi = '0, md_lo = '0;
  logic [3:0]    md_op;
  logic [DW-1:0] md_a1, md_a2, mf_data;
  logic          md_req, stall, mf_valid, wd_err;

  md_issue_ctl #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .e_md_op(e_md_op), .e_mf_sel(e_mf_sel),
    .e_rs(e_rs), .e_rt(e_rt), .int_req(int_req), .md_busy(md_busy),
    .md_hi(md_hi), .md_lo(md_lo), .md_op(md_op), .md_a1(md_a1), .md_a2(md_a2),
    .md_req(md_req), .stall(stall), .mf_data(mf_data), .mf_valid(mf_valid),
    .wd_err(wd_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: what the controller has on md_op, whether it still waits on the unit
  logic [3:0]    m_op;
  logic [DW-1:0] m_a1, m_a2, m_mf_data;
  logic          m_mf_valid, m_wd;
  bit            m_await;
  int            m_waited;

  // Behavioural MD unit: 5-cycle multiply, 10-cycle divide, immediate MTLO/MTHI
  int            md_cnt;
  logic [DW-1:0] res_hi, res_lo;
  bit            force_busy;
  logic          nb;
  logic [DW-1:0] nh, nl;
  bit            last_stall;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_op = 4'd0; m_a1 = '0; m_a2 = '0; m_mf_data = '0;
    m_mf_valid = 1'b0; m_wd = 1'b0; m_await = 1'b0; m_waited = 0;
  endtask

  task automatic check_all();
    logic needs;
    needs = (e_md_op != 4'd0) || (e_mf_sel == 2'b01) || (e_mf_sel == 2'b10);
    chk32("md_op", 32'(md_op), 32'(m_op));
    chk32("md_a1", md_a1, m_a1);
    chk32("md_a2", md_a2, m_a2);
    chk32("mf_data", mf_data, m_mf_data);
    chk1("mf_valid", mf_valid, m_mf_valid);
    chk1("wd_err", wd_err, m_wd);
    chk1("stall", stall, ((m_op != 4'd0) || m_await) && needs);
    chk1("md_req", md_req, int_req && reset);
  endtask

  task automatic model_step();
    logic [3:0] pres;
    bit free;
    pres = m_op;
    free = (m_op == 4'd0) && !m_await;
    m_mf_valid = 1'b0;
    m_op = 4'd0;
    if (free) begin
      if (e_md_op != 4'd0) begin
        if (!int_req) begin
          m_op = e_md_op; m_a1 = e_rs; m_a2 = e_rt;
        end
      end else if (e_mf_sel == 2'b01 || e_mf_sel == 2'b10) begin
        m_mf_valid = 1'b1;
        m_mf_data = (e_mf_sel == 2'b01) ? md_hi : md_lo;
      end
    end else if (pres != 4'd0) begin
      if (!int_req && pres <= 4'd4) begin
        m_await = 1'b1; m_waited = 0;
      end
    end else begin
      if (!md_busy) m_await = 1'b0;
      else begin
        m_waited++;
        if (m_waited >= TO) begin
          m_wd = 1'b1; m_await = 1'b0;
        end
      end
    end
  endtask

  task automatic env_step();
    logic signed [63:0] sa, sb, p, q, r;
    logic [63:0] up;
    nh = md_hi; nl = md_lo;
    if (!reset) begin
      md_cnt = 0;
      nb = 1'b0;
    end else begin
      if (md_cnt > 0) begin
        md_cnt--;
        if (md_cnt == 0) begin nh = res_hi; nl = res_lo; end
      end
      if (md_op != 4'd0 && !md_req) begin
        sa = {{32{md_a1[31]}}, md_a1};
        sb = {{32{md_a2[31]}}, md_a2};
        case (md_op)
          4'd1: begin p = sa * sb; res_hi = p[63:32]; res_lo = p[31:0]; md_cnt = 5; end
          4'd2: begin up = {32'h0, md_a1} * {32'h0, md_a2}; res_hi = up[63:32]; res_lo = up[31:0]; md_cnt = 5; end
          4'd3, 4'd4: begin
            if (md_a2 == 32'h0) begin
              res_lo = 32'hFFFF_FFFF; res_hi = md_a1;
            end else if (md_op == 4'd3) begin
              q = sa / sb; r = sa % sb; res_lo = q[31:0]; res_hi = r[31:0];
            end else begin
              res_lo = md_a1 / md_a2; res_hi = md_a1 % md_a2;
            end
            md_cnt = 10;
          end
          4'd5: nl = md_a1;
          4'd6: nh = md_a1;
          default: ;
        endcase
      end
      nb = (md_cnt > 0) || force_busy;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
    last_stall = stall;
    if (reset) model_step();
    env_step();
    @(posedge clk);
    #1;
    md_busy = nb; md_hi = nh; md_lo = nl;
  endtask

  task automatic run_until_mf(input int budget, output int stalls);
    int n;
    bit got;
    stalls = 0; n = 0; got = 1'b0;
    while (!got && n < budget) begin
      cycle();
      if (last_stall) stalls++;
      got = mf_valid;
      n++;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL mf_timeout: no mf_valid within %0d cycles", budget);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int s;
    int r;
    model_reset();
    md_cnt = 0; force_busy = 1'b0; last_stall = 1'b0;

    // Reset state
    cycle();
    chk32("rst_md_op", 32'(md_op), 32'd0);
    chk1("rst_stall", stall, 1'b0);
    chk1("rst_wd", wd_err, 1'b0);
    cycle();
    reset = 1'b1;

    // MULT 3*7 then MFLO held by stall
    e_md_op = 4'd1; e_rs = 32'd3; e_rt = 32'd7;
    cycle();
    chk32("t1_op", 32'(md_op), 32'd1);
    chk32("t1_a1", md_a1, 32'd3);
    chk32("t1_a2", md_a2, 32'd7);
    e_md_op = 4'd0; e_mf_sel = 2'b10;
    cycle();
    chk32("t1_oneshot", 32'(md_op), 32'd0);
    run_until_mf(40, s);
    chk32("t1_mflo", mf_data, 32'd21);
    e_mf_sel = 2'b00;

    // MTHI then MFHI: one stall cycle
    e_md_op = 4'd6; e_rs = 32'hDEAD_BEEF;
    cycle();
    e_md_op = 4'd0; e_mf_sel = 2'b01;
    run_until_mf(10, s);
    chk32("t2_stalls", 32'(s), 32'd1);
    chk32("t2_mfhi", mf_data, 32'hDEAD_BEEF);
    e_mf_sel = 2'b00;

    // DIV cancelled by int_req in its ISSUED cycle
    e_md_op = 4'd3; e_rs = 32'd100; e_rt = 32'd7;
    cycle();
    e_md_op = 4'd0; int_req = 1'b1;
    #1;
    chk1("t3_md_req", md_req, 1'b1);
    cycle();
    int_req = 1'b0; e_mf_sel = 2'b10;
    #1;
    chk1("t3_no_stall", stall, 1'b0);
    run_until_mf(5, s);
    chk32("t3_old_lo", mf_data, 32'd21);
    e_mf_sel = 2'b00;

    // int_req in IDLE drops MULTU
    e_md_op = 4'd2; int_req = 1'b1;
    #1;
    chk1("t4_no_stall", stall, 1'b0);
    cycle();
    chk32("t4_no_op", 32'(md_op), 32'd0);
    e_md_op = 4'd0; int_req = 1'b0;
    cycle();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if (!last_stall) begin
        r = $urandom_range(0, 9);
        e_md_op  = (r < 3) ? 4'($urandom_range(1, 6)) : 4'd0;
        e_mf_sel = (r >= 2 && r < 7) ? 2'($urandom_range(1, 3)) : 2'd0;
        e_rs = $urandom;
        e_rt = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      end
      int_req = ($urandom_range(0, 11) == 0);
      cycle();
    end
    e_md_op = 4'd0; e_mf_sel = 2'd0; int_req = 1'b0;
    for (int i = 0; i < 15; i++) cycle();

    // Watchdog: busy stuck high
    force_busy = 1'b1;
    e_md_op = 4'd1; e_rs = 32'd9; e_rt = 32'd9;
    cycle();
    e_md_op = 4'd0; e_mf_sel = 2'b10;
    run_until_mf(60, s);
    chk1("t5_wd", wd_err, 1'b1);
    chk32("t5_stalls", 32'(s), 32'd16);
    e_mf_sel = 2'b00; force_busy = 1'b0;
    cycle();
    cycle();

    // Reset during WAIT of DIVU
    e_md_op = 4'd4; e_rs = 32'd50; e_rt = 32'd5;
    cycle();
    cycle();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk32("t6_op", 32'(md_op), 32'd0);
    chk32("t6_a1", md_a1, 32'd0);
    chk32("t6_data", mf_data, 32'd0);
    chk1("t6_wd", wd_err, 1'b0);
    chk1("t6_stall", stall, 1'b0);
    cycle();
    cycle();
    reset = 1'b1;
    e_md_op = 4'd1; e_rs = 32'd5; e_rt = 32'd6; e_mf_sel = 2'b00;
    cycle();
    chk32("t6_mult_op", 32'(md_op), 32'd1);
    chk32("t6_mult_a1", md_a1, 32'd5);
    e_md_op = 4'd0; e_mf_sel = 2'b10;
    run_until_mf(40, s);
    chk32("t6_mult_lo", mf_data, 32'd30);
    e_mf_sel = 2'b00;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
